// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between two valid/ready requesters.
// Operands and result are registered; one operation is in flight at a time (IDLE -> EXEC -> RESP).
module alu_share_arbiter #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req1_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_opcode,
  input  logic [DATA_W-1:0] alu_c,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_data,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_data,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] op_a_q, op_a_d;
  logic [DATA_W-1:0] op_b_q, op_b_d;
  logic [OP_W-1:0]   op_code_q, op_code_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              owner_q, owner_d;
  logic              last_grant_q, last_grant_d;
  logic              grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_code_q    <= '0;
      res_q        <= '0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      op_code_q    <= op_code_d;
      res_q        <= res_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    op_code_d    = op_code_q;
    res_d        = res_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;

    // A tie goes to the port that was not served last.
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = ~last_grant_q;
    else if (req1_valid)          grant = 1'b1;

    unique case (state_q)
      IDLE: begin
        req0_ready = req0_valid && !grant;
        req1_ready = req1_valid && grant;
        if (req0_ready || req1_ready) begin
          op_a_d       = grant ? req1_a  : req0_a;
          op_b_d       = grant ? req1_b  : req0_b;
          op_code_d    = grant ? req1_op : req0_op;
          owner_d      = grant;
          last_grant_d = grant;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        res_d   = alu_c;
        state_d = RESP;
      end
      RESP: begin
        if (owner_q ? rsp1_ready : rsp0_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The ALU inputs come straight from the operand registers, so they only move on accept.
  assign alu_a      = op_a_q;
  assign alu_b      = op_b_q;
  assign alu_opcode = op_code_q;

  assign rsp0_valid = (state_q == RESP) && !owner_q;
  assign rsp1_valid = (state_q == RESP) && owner_q;
  assign rsp0_data  = res_q;
  assign rsp1_data  = res_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a reference ALU and a response scoreboard.
module tb_alu_share_arbiter;
  localparam int DATA_W = 32;
  localparam int OP_W   = 6;

  logic              clk, rst;
  logic              req0_valid, req0_ready, req1_valid, req1_ready;
  logic [DATA_W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [OP_W-1:0]   req0_op, req1_op;
  logic [DATA_W-1:0] alu_a, alu_b, alu_c;
  logic [OP_W-1:0]   alu_opcode;
  logic              rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready, busy;
  logic [DATA_W-1:0] rsp0_data, rsp1_data;

  typedef struct packed {
    logic              port;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [DATA_W-1:0] alu_model(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                                  input logic [OP_W-1:0] op);
    case (op)
      6'd5:    return a - b;
      6'd6:    return a + b;
      6'd7:    return a ^ b;
      6'd8:    return a | (b << 1);
      6'd9:    return a << b[4:0];
      6'd10:   return a >> b[4:0];
      6'd11:   return $signed(a) >>> b[4:0];
      6'd12:   return {31'b0, $signed(a) < $signed(b)};
      6'd13:   return {31'b0, a < b};
      default: return (a - b) ^ {26'b0, op};
    endcase
  endfunction

  assign alu_c = alu_model(alu_a, alu_b, alu_opcode);

  alu_share_arbiter #(.DATA_W(DATA_W), .OP_W(OP_W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_c(alu_c),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] expv);
    checks++;
    assert (got === expv) else begin
      errors++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, expv);
    end
  endtask

  // Scoreboard: every consumed response must match the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (rsp0_valid && rsp1_valid) chk("both_rsp_valid", 1'b1, 1'b0);
      if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", {31'b0, rsp1_valid}, {31'b0, 1'b0} + 32'd2);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_port", {31'b0, rsp1_valid}, {31'b0, e.port});
          chk("rsp_data", rsp1_valid ? rsp1_data : rsp0_data, e.data);
        end
      end
    end
  end

  task automatic wait_grant(input logic exp_port, output int waited);
    bit   got_it = 0;
    logic gp;
    exp_t e;
    waited = 0;
    for (int i = 0; i < 30 && !got_it; i++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) got_it = 1;
      else waited++;
    end
    chk("grant_timeout", {31'b0, got_it}, 32'd1);
    if (!got_it) return;
    gp = req1_ready;
    chk("grant_port", {31'b0, gp}, {31'b0, exp_port});
    chk("one_ready", {31'b0, req0_ready & req1_ready}, 32'd0);
    e.port = gp;
    e.data = gp ? alu_model(req1_a, req1_b, req1_op) : alu_model(req0_a, req0_b, req0_op);
    exp_q.push_back(e);
    @(posedge clk); #1;
    if (gp) req1_valid = 1'b0;
    else    req0_valid = 1'b0;
  endtask

  task automatic drive(input logic port, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                       input logic [OP_W-1:0] op);
    if (port) begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op; end
    else      begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op; end
  endtask

  task automatic drain();
    bit done = 0;
    for (int i = 0; i < 30 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) done = 1;
    end
    chk("drain_timeout", {31'b0, done}, 32'd1);
  endtask

  task automatic do_reset();
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #3 rst = 1'b1;
    @(posedge clk); #3 rst = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    int w;
    int n;
    logic [DATA_W-1:0] hold;
    rst = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    #12;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_rsp_valid", {30'b0, rsp1_valid, rsp0_valid}, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    #11 rst = 1'b0;

    // Port 0 alone: immediate accept, response two edges after accept.
    @(posedge clk); #1;
    drive(1'b0, 32'd123, 32'd124, 6'd8);
    wait_grant(1'b0, w);
    chk("t1_ready_same_cycle", w, 32'd0);
    @(negedge clk);
    chk("t1_exec_rsp0_valid", {31'b0, rsp0_valid}, 32'd0);
    chk("t1_exec_busy", {31'b0, busy}, 32'd1);
    chk("t1_exec_alu_a", alu_a, 32'd123);
    chk("t1_exec_alu_op", {26'b0, alu_opcode}, 32'd8);
    @(negedge clk);
    chk("t1_rsp0_valid", {31'b0, rsp0_valid}, 32'd1);
    chk("t1_rsp1_valid", {31'b0, rsp1_valid}, 32'd0);
    drain();

    // Tie after reset goes to port 0, then strict alternation.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, -32'd221 + k, -32'd122, 6'd7);
      drive(1'b1, 32'd1223 + k, 32'd3, 6'd6);
      wait_grant(1'b0, w);
      wait_grant(1'b1, w);
    end
    drain();

    // Backpressure on port 1 with port 0 waiting.
    @(posedge clk); #1;
    rsp1_ready = 1'b0;
    drive(1'b1, 32'hdead_0001, 32'd7, 6'd20);
    wait_grant(1'b1, w);
    @(negedge clk); @(negedge clk);
    drive(1'b0, 32'd55, 32'd66, 6'd9);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t3_rsp1_valid", {31'b0, rsp1_valid}, 32'd1);
      chk("t3_rsp1_data", rsp1_data, alu_model(32'hdead_0001, 32'd7, 6'd20));
      chk("t3_busy", {31'b0, busy}, 32'd1);
      chk("t3_req0_ready", {31'b0, req0_ready}, 32'd0);
    end
    @(posedge clk); #1 rsp1_ready = 1'b1;
    @(posedge clk); #1;
    chk("t3_idle_after_release", {31'b0, busy}, 32'd0);
    wait_grant(1'b0, w);
    chk("t3_req0_ready_wait", w, 32'd0);
    drain();

    // Operand change after accept must not reach the ALU.
    @(posedge clk); #1;
    drive(1'b0, 32'h1234_5678, 32'd4, 6'd10);
    wait_grant(1'b0, w);
    req0_a = 32'hffff_0000;
    @(negedge clk);
    chk("t4_alu_a_exec", alu_a, 32'h1234_5678);
    @(posedge clk); #4;
    chk("t4_alu_a_resp", alu_a, 32'h1234_5678);
    drain();

    // Reset in the middle of EXEC discards the op.
    @(posedge clk); #1;
    drive(1'b0, 32'd999, 32'd1, 6'd5);
    wait_grant(1'b0, w);
    #2 rst = 1'b1;
    #1;
    chk("t5_busy", {31'b0, busy}, 32'd0);
    chk("t5_rsp_valid", {30'b0, rsp1_valid, rsp0_valid}, 32'd0);
    chk("t5_alu_a", alu_a, 32'd0);
    chk("t5_alu_b", alu_b, 32'd0);
    chk("t5_alu_op", {26'b0, alu_opcode}, 32'd0);
    exp_q.delete();
    @(posedge clk); #3 rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("t5_no_stale_rsp", {30'b0, rsp1_valid, rsp0_valid}, 32'd0);
    @(posedge clk); #1;
    drive(1'b0, 32'd31, 32'd17, 6'd13);
    drive(1'b1, 32'd41, 32'd19, 6'd12);
    wait_grant(1'b0, w);
    wait_grant(1'b1, w);
    drain();

    // Opcode sweep alternating ports.
    n = 0;
    for (int op = 5; op <= 27; op++) begin
      if (op >= 14 && op <= 17) continue;
      @(posedge clk); #1;
      drive(n[0], -32'd1223, 32'd3, op[OP_W-1:0]);
      wait_grant(n[0], w);
      n++;
    end
    drain();
    hold = exp_q.size();
    chk("final_queue_empty", hold, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
